// File: rtl/change_return_sequencer.sv
// Change-return sequencer: splits an amount greedily into 20/10/5-cent returns
// and emits them as non-overlapping fixed-width pulses separated by fixed gaps.
module change_return_sequencer #(
  parameter int W            = 6,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         r5,
  output logic         r10,
  output logic         r20,
  output logic [W-1:0] remaining,
  output logic [3:0]   coin_count,
  output logic         err_residue
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_5, SEL_10, SEL_20} sel_t;

  state_t         state_q, state_d;
  sel_t           sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   remaining_q, remaining_d;
  logic [3:0]     coin_count_q, coin_count_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           r5_q, r5_d, r10_q, r10_d, r20_q, r20_d;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    remaining_d  = remaining_q;
    coin_count_d = coin_count_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d  = amount;
          coin_count_d = 4'd0;
          err_d        = 1'b0;
          state_d      = S_SELECT;
        end
      end
      S_SELECT: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (remaining_q >= W'(20)) begin
          sel_d       = SEL_20;
          remaining_d = remaining_q - W'(20);
        end else if (remaining_q >= W'(10)) begin
          sel_d       = SEL_10;
          remaining_d = remaining_q - W'(10);
        end else if (remaining_q >= W'(5)) begin
          sel_d       = SEL_5;
          remaining_d = remaining_q - W'(5);
        end else begin
          state_d = S_DONE;
        end
        if (state_d == S_SELECT) begin
          coin_count_d = sat_inc4(coin_count_q);
          cnt_d        = CNT_W'(PULSE_CYCLES - 1);
          state_d      = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    if (state_d == S_DONE) err_d = (remaining_d != '0);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    r5_d   = (state_d == S_PULSE) && (sel_d == SEL_5);
    r10_d  = (state_d == S_PULSE) && (sel_d == SEL_10);
    r20_d  = (state_d == S_PULSE) && (sel_d == SEL_20);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_NONE;
      cnt_q        <= '0;
      remaining_q  <= '0;
      coin_count_q <= 4'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      r5_q         <= 1'b0;
      r10_q        <= 1'b0;
      r20_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      remaining_q  <= remaining_d;
      coin_count_q <= coin_count_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      r5_q         <= r5_d;
      r10_q        <= r10_d;
      r20_q        <= r20_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign r5          = r5_q;
  assign r10         = r10_q;
  assign r20         = r20_q;
  assign remaining   = remaining_q;
  assign coin_count  = coin_count_q;
  assign err_residue = err_q;

endmodule

// File: tb/tb_change_return_sequencer.sv
// Directed bench for change_return_sequencer with default PULSE=4, GAP=2:
// each coin takes 7 cycles, done arrives 2 + 7*N cycles after start.
module tb_change_return_sequencer;

  localparam logic [2:0] R20 = 3'b100;
  localparam logic [2:0] R10 = 3'b010;
  localparam logic [2:0] R5  = 3'b001;
  localparam logic [2:0] RNO = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] amount = 6'd0;
  logic       abort = 1'b0;
  logic       busy, done, r5, r10, r20, err_residue;
  logic [5:0] remaining;
  logic [3:0] coin_count;

  int checks = 0;
  int errors = 0;

  change_return_sequencer #(.W(6), .PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .abort(abort),
    .busy(busy), .done(done), .r5(r5), .r10(r10), .r20(r20),
    .remaining(remaining), .coin_count(coin_count), .err_residue(err_residue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({busy, done, r20, r10, r5});
  endfunction

  // Full sequence with per-cycle check of {busy,done,r20,r10,r5}.
  task automatic run(input string tag, input logic [5:0] amt, input int n,
                     input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                     input logic [5:0] exp_rem, input logic exp_err,
                     input int restart_k, input logic abort_with_start);
    logic [2:0] coins [3];
    logic [4:0] exp_ctl;
    int last;
    coins[0] = c0; coins[1] = c1; coins[2] = c2;
    last = 2 + 7 * n;
    start = 1'b1; amount = amt; abort = abort_with_start;
    tick();
    start = 1'b0; abort = 1'b0;
    chk($sformatf("%s k1 ctl", tag), ctl(), 32'(5'b10000));
    chk($sformatf("%s k1 remaining", tag), 32'(remaining), 32'(amt));
    chk($sformatf("%s k1 coin_count", tag), 32'(coin_count), 32'd0);
    chk($sformatf("%s k1 err", tag), 32'(err_residue), 32'd0);
    for (int k = 2; k <= last; k++) begin
      if (k == restart_k) begin
        start = 1'b1; amount = 6'd55;
      end
      tick();
      start = 1'b0;
      exp_ctl = {1'b1, (k == last), 3'b000};
      if (k < last && ((k - 2) % 7) < 4) exp_ctl[2:0] = coins[(k - 2) / 7];
      chk($sformatf("%s k%0d ctl", tag, k), ctl(), 32'(exp_ctl));
    end
    chk($sformatf("%s done remaining", tag), 32'(remaining), 32'(exp_rem));
    chk($sformatf("%s done coin_count", tag), 32'(coin_count), 32'(n));
    chk($sformatf("%s done err", tag), 32'(err_residue), 32'(exp_err));
    tick();
    chk($sformatf("%s idle ctl", tag), ctl(), 32'd0);
    chk($sformatf("%s idle remaining held", tag), 32'(remaining), 32'(exp_rem));
    chk($sformatf("%s idle err held", tag), 32'(err_residue), 32'(exp_err));
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    tick();
    tick();
    chk("reset ctl", ctl(), 32'd0);
    chk("reset remaining", 32'(remaining), 32'd0);
    chk("reset coin_count", 32'(coin_count), 32'd0);
    chk("reset err", 32'(err_residue), 32'd0);
    reset = 1'b0;
    tick();

    // Greedy sequences
    run("amt25", 6'd25, 2, R20, R5, RNO, 6'd0, 1'b0, 0, 1'b0);
    run("amt0",  6'd0,  0, RNO, RNO, RNO, 6'd0, 1'b0, 0, 1'b0);
    run("amt63", 6'd63, 3, R20, R20, R20, 6'd3, 1'b1, 0, 1'b0);
    run("amt35", 6'd35, 3, R20, R10, R5, 6'd0, 1'b0, 0, 1'b0);

    // Abort during second r20 pulse of 40
    start = 1'b1; amount = 6'd40;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    chk("abort_pulse pre ctl", ctl(), 32'(5'b10100));
    chk("abort_pulse pre remaining", 32'(remaining), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pulse ctl", ctl(), 32'(5'b11000));
    chk("abort_pulse coin_count", 32'(coin_count), 32'd2);
    chk("abort_pulse remaining", 32'(remaining), 32'd0);
    chk("abort_pulse err", 32'(err_residue), 32'd0);
    tick();
    chk("abort_pulse idle ctl", ctl(), 32'd0);

    // Abort during first gap of 40
    start = 1'b1; amount = 6'd40;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    chk("abort_gap pre ctl", ctl(), 32'(5'b10000));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gap ctl", ctl(), 32'(5'b11000));
    chk("abort_gap coin_count", 32'(coin_count), 32'd1);
    chk("abort_gap remaining", 32'(remaining), 32'd20);
    chk("abort_gap err", 32'(err_residue), 32'd1);
    tick();
    chk("abort_gap idle ctl", ctl(), 32'd0);

    // Abort alone in IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle ctl", ctl(), 32'd0);
    chk("abort_idle err held", 32'(err_residue), 32'd1);
    chk("abort_idle remaining held", 32'(remaining), 32'd20);

    // Start while busy is ignored; accepted start clears err
    run("restart", 6'd10, 1, R10, RNO, RNO, 6'd0, 1'b0, 4, 1'b0);
    // Start together with abort in IDLE: start wins
    run("abort_start", 6'd5, 1, R5, RNO, RNO, 6'd0, 1'b0, 0, 1'b1);

    // Async reset mid-pulse
    start = 1'b1; amount = 6'd20;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rst_mid pre ctl", ctl(), 32'(5'b10100));
    #1 reset = 1'b1;
    #1;
    chk("rst_mid async ctl", ctl(), 32'd0);
    chk("rst_mid async remaining", 32'(remaining), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid after ctl", ctl(), 32'd0);
    run("post_rst10", 6'd10, 1, R10, RNO, RNO, 6'd0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
